// File: rtl/pwm_regs_pkg.sv
// pwm_regs_pkg: register map, ctrl bit positions and period derivation for pwm_multi_channel
package pwm_regs_pkg;
  localparam int ADDR_EN_OUT = 'h00;
  localparam int ADDR_EN_PWM = 'h04;
  localparam int ADDR_PRESC = 'h08;
  localparam int ADDR_CTRL = 'h09;
  localparam int ADDR_DUTY_BASE = 'h10;
  localparam int CTRL_STAGGER = 0;
  localparam int CTRL_LOCK = 1;
  function automatic int max_period(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one PWM lane with boundary-loaded duty shadow, phase-offset compare, gating and output flop
module pwm_channel
  import pwm_regs_pkg::*;
#(
  parameter int DUTY_W = 8,
  parameter int PHASE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] cnt,
  input  logic              boundary,
  input  logic              lock,
  input  logic [DUTY_W-1:0] duty_wr,
  input  logic              en_out,
  input  logic              en_pwm,
  input  logic              stagger,
  output logic              out
);
  localparam logic [DUTY_W:0] MAX = (DUTY_W + 1)'(max_period(DUTY_W));
  localparam logic [DUTY_W:0] PH = (DUTY_W + 1)'(PHASE);
  logic [DUTY_W-1:0] duty_sh;
  logic [DUTY_W:0] sum, pos;
  always_comb begin
    sum = {1'b0, cnt} + MAX - (stagger ? PH : '0);
    pos = sum >= MAX ? sum - MAX : sum;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh <= '0;
      out <= 1'b0;
    end else begin
      if (boundary && !lock) duty_sh <= duty_wr;
      out <= en_out ? (en_pwm ? pos < {1'b0, duty_sh} : 1'b1) : 1'b0;
    end
  end
endmodule

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: NUM_CH PWM outputs behind a byte register port, with prescaler, double-buffered duty, lock and stagger
module pwm_multi_channel
  import pwm_regs_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int DUTY_W = 8,
  parameter int PRESC_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);
  localparam int MAX = max_period(DUTY_W);
  localparam int STEP = MAX / NUM_CH;
  logic [NUM_CH-1:0] en_out, en_pwm;
  logic [PRESC_W-1:0] presc, presc_cnt;
  logic [1:0] ctrl;
  logic [DUTY_W-1:0] duty_wr [NUM_CH];
  logic [DUTY_W-1:0] cnt;
  logic tick, boundary;
  logic [7:0] rd_next;
  int wa, ra;
  assign wa = int'(wr_addr);
  assign ra = int'(rd_addr);
  assign tick = presc_cnt >= presc;
  assign boundary = tick && cnt == DUTY_W'(MAX - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      cnt <= '0;
      period_start <= 1'b0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
      cnt <= boundary ? '0 : cnt + DUTY_W'(tick);
      period_start <= boundary;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      en_out <= '0;
      en_pwm <= '0;
      presc <= '0;
      ctrl <= '0;
      for (int c = 0; c < NUM_CH; c++) duty_wr[c] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NUM_CH; b++) begin
        if (wa == ADDR_EN_OUT + b / 8) en_out[b] <= wr_data[3'(b)];
        if (wa == ADDR_EN_PWM + b / 8) en_pwm[b] <= wr_data[3'(b)];
      end
      if (wa == ADDR_PRESC) presc <= PRESC_W'(wr_data);
      if (wa == ADDR_CTRL) ctrl <= wr_data[1:0];
      for (int c = 0; c < NUM_CH; c++)
        if (wa == ADDR_DUTY_BASE + c) duty_wr[c] <= DUTY_W'(wr_data);
    end
  end
  always_comb begin
    rd_next = '0;
    for (int b = 0; b < NUM_CH; b++) begin
      if (ra == ADDR_EN_OUT + b / 8) rd_next[3'(b)] = en_out[b];
      if (ra == ADDR_EN_PWM + b / 8) rd_next[3'(b)] = en_pwm[b];
    end
    if (ra == ADDR_PRESC) rd_next = 8'(presc);
    if (ra == ADDR_CTRL) rd_next = {6'b0, ctrl};
    for (int c = 0; c < NUM_CH; c++)
      if (ra == ADDR_DUTY_BASE + c) rd_next = 8'(duty_wr[c]);
  end
  always_ff @(posedge clk) rd_data <= rst ? '0 : rd_next;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(.DUTY_W(DUTY_W), .PHASE(i * STEP)) u_ch (
      .clk(clk),
      .rst(rst),
      .cnt(cnt),
      .boundary(boundary),
      .lock(ctrl[CTRL_LOCK]),
      .duty_wr(duty_wr[i]),
      .en_out(en_out[i]),
      .en_pwm(en_pwm[i]),
      .stagger(ctrl[CTRL_STAGGER]),
      .out(out[i])
    );
  end
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: scoreboard bench with a tick/period reference model for pwm_multi_channel
module tb_pwm_multi_channel;
  localparam int NUM_CH = 16;
  localparam int MAX = 255;
  logic clk = 1'b0;
  logic rst, wr_en;
  logic [6:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;
  logic [NUM_CH-1:0] out;
  logic period_start;
  always #5 clk = ~clk;
  pwm_multi_channel #(.NUM_CH(NUM_CH), .DUTY_W(8), .PRESC_W(8), .ADDR_W(7)) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .out(out),
    .period_start(period_start)
  );
  typedef struct packed {
    logic [NUM_CH-1:0] o;
    logic ps;
    logic [7:0] rd;
  } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  longint unsigned m_eo, m_ep;
  int m_presc, m_stag, m_lock, m_cnt, m_since;
  int m_wr[NUM_CH], m_sh[NUM_CH];
  int h, p;
  int rise[NUM_CH];
  logic [NUM_CH-1:0] prev;
  function automatic void model_reset();
    m_eo = 0;
    m_ep = 0;
    m_presc = 0;
    m_stag = 0;
    m_lock = 0;
    m_cnt = 0;
    m_since = 0;
    foreach (m_wr[i]) begin
      m_wr[i] = 0;
      m_sh[i] = 0;
    end
  endfunction
  function automatic int reg_rd(int a);
    if (a < 4) return int'((m_eo >> (8 * a)) & 255);
    if (a < 8) return int'((m_ep >> (8 * (a - 4))) & 255);
    if (a == 8) return m_presc;
    if (a == 9) return m_stag + 2 * m_lock;
    if (a >= 16 && a < 16 + NUM_CH) return m_wr[a - 16];
    return 0;
  endfunction
  function automatic void m_write(int a, int d);
    longint unsigned mask = (64'd1 << NUM_CH) - 1;
    longint unsigned bm = 64'hFF << (8 * (a % 4));
    longint unsigned dv = longint'(d) << (8 * (a % 4));
    if (a < 4) m_eo = ((m_eo & ~bm) | dv) & mask;
    else if (a < 8) m_ep = ((m_ep & ~bm) | dv) & mask;
    else if (a == 8) m_presc = d;
    else if (a == 9) begin
      m_stag = d & 1;
      m_lock = (d >> 1) & 1;
    end else if (a >= 16 && a < 16 + NUM_CH) m_wr[a - 16] = d;
  endfunction
  function automatic bit m_boundary_next();
    return m_since >= m_presc && m_cnt == MAX - 1;
  endfunction
  task automatic step();
    exp_t e;
    bit tick, bnd;
    int ph, pos;
    e = '0;
    if (rst) model_reset();
    else begin
      tick = m_since >= m_presc;
      bnd = tick && m_cnt == MAX - 1;
      for (int i = 0; i < NUM_CH; i++) begin
        ph = m_stag ? i * (MAX / NUM_CH) : 0;
        pos = (m_cnt - ph + MAX) % MAX;
        e.o[i] = m_eo[i] ? (m_ep[i] ? (pos < m_sh[i]) : 1'b1) : 1'b0;
      end
      e.ps = bnd;
      e.rd = 8'(reg_rd(int'(rd_addr)));
      m_since = tick ? 0 : m_since + 1;
      m_cnt = (m_cnt + int'(tick)) % MAX;
      if (bnd && !m_lock) m_sh = m_wr;
      if (wr_en) m_write(int'(wr_addr), int'(wr_data));
    end
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (out !== e.o || period_start !== e.ps || rd_data !== e.rd) begin
        miscompares++;
        $display("FAIL cycle t=%0t: out=%h period_start=%b rd_data=%h, expected out=%h period_start=%b rd_data=%h",
                 $time, out, period_start, rd_data, e.o, e.ps, e.rd);
      end
    end
  end
  task automatic check(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask
  task automatic wr(int a, int d);
    wr_en = 1'b1;
    wr_addr = 7'(a);
    wr_data = 8'(d);
    step();
    wr_en = 1'b0;
  endtask
  task automatic idle(int n);
    repeat (n) step();
  endtask
  task automatic measure(int ch, int n, output int hi, output int ps);
    hi = 0;
    ps = 0;
    repeat (n) begin
      step();
      hi += int'(out[ch]);
      ps += int'(period_start);
    end
  endtask
  task automatic wr_on_boundary(int a, int d);
    int n = 0;
    while (!m_boundary_next() && n < 5000) begin
      step();
      n++;
    end
    wr(a, d);
  endtask
  task automatic rd_check(string name, int a, int want);
    rd_addr = 7'(a);
    step();
    check(name, int'(rd_data), want);
  endtask
  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    idle(2);
    check("reset out", int'(out), 0);
    check("reset period_start", int'(period_start), 0);
    rst = 1'b0;
    for (int a = 0; a < 128; a++) begin
      rd_addr = 7'(a);
      step();
    end
    rd_addr = 7'h10;
    wr(0, 1);
    wr(4, 1);
    wr(16, 'h80);
    idle(2 * MAX);
    measure(0, MAX, h, p);
    check("duty80 high", h, 128);
    check("duty80 pstart", p, 1);
    wr(8, 3);
    idle(8 * MAX);
    measure(0, 4 * MAX, h, p);
    check("presc3 high", h, 512);
    check("presc3 pstart", p, 1);
    wr(8, 0);
    wr(16, 0);
    idle(2 * MAX);
    measure(0, MAX, h, p);
    check("duty00 high", h, 0);
    wr(16, 'hFF);
    idle(2 * MAX);
    measure(0, MAX, h, p);
    check("dutyFF high", h, MAX);
    wr(4, 0);
    wr(16, 0);
    idle(2);
    measure(0, 50, h, p);
    check("en_pwm0 const1", h, 50);
    wr(0, 0);
    wr(16, 'hFF);
    idle(2);
    measure(0, 50, h, p);
    check("en_out0 const0", h, 0);
    wr('h7F, 'hAA);
    wr(16 + NUM_CH, 'h55);
    wr(3, 'hFF);
    rd_check("rd 7F", 'h7F, 0);
    rd_check("rd duty oob", 16 + NUM_CH, 0);
    rd_check("rd en_out byte3", 3, 0);
    wr(0, 'h08);
    wr(4, 'h08);
    wr(19, 'h40);
    idle(2 * MAX);
    wr_on_boundary(19, 'hC0);
    measure(3, MAX, h, p);
    check("boundary write old period", h, 64);
    measure(3, MAX, h, p);
    check("boundary write new period", h, 192);
    wr(9, 2);
    wr(19, 'h20);
    idle(2 * MAX);
    measure(3, MAX, h, p);
    check("lock holds", h, 192);
    wr(9, 0);
    idle(2 * MAX);
    measure(3, MAX, h, p);
    check("unlock updates", h, 32);
    for (int a = 0; a < 2; a++) begin
      wr(a, 'hFF);
      wr(4 + a, 'hFF);
    end
    for (int i = 0; i < NUM_CH; i++) wr(16 + i, 'h10);
    wr(9, 1);
    idle(2 * MAX);
    foreach (rise[i]) rise[i] = -1;
    prev = out;
    for (int k = 0; k < 2 * MAX; k++) begin
      step();
      for (int i = 0; i < NUM_CH; i++)
        if (out[i] && !prev[i] && rise[i] < 0) rise[i] = k;
      prev = out;
    end
    for (int i = 0; i < NUM_CH; i++)
      check($sformatf("stagger ch%0d offset", i),
            (rise[i] < 0 || rise[0] < 0) ? -1 : (rise[i] - rise[0] + MAX) % MAX, 15 * i);
    for (int k = 0; k < 6000; k++) begin
      int a;
      rd_addr = 7'($urandom_range(0, 40));
      rst = $urandom_range(0, 199) == 0;
      wr_en = $urandom_range(0, 5) == 0;
      case ($urandom_range(0, 4))
        0: a = $urandom_range(0, 9);
        1: a = 16 + $urandom_range(0, NUM_CH);
        2: a = $urandom_range(0, 127);
        default: a = 16 + $urandom_range(0, 3);
      endcase
      wr_addr = 7'(a);
      wr_data = a == 8 ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      step();
      rst = 1'b0;
      wr_en = 1'b0;
    end
    idle(2);
    check("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
